// File: rtl/task_scheduler_if.sv
// Command/response bus between the task scheduler (master) and the ready list (slave).
// The ready list samples rl_tid_o/rl_priority_o over several cycles after a strobe.
interface task_scheduler_if;
    logic       rl_insert_o;
    logic       rl_remove_o;
    logic       rl_get_o;
    logic [3:0] rl_tid_o;
    logic [2:0] rl_priority_o;
    logic [4:0] rl_tid_i;
    logic       rl_done_i;

    // Strobes are one-hot and one cycle wide; rl_done_i is high while the ready list is idle.
    modport master (
        output rl_insert_o, rl_remove_o, rl_get_o, rl_tid_o, rl_priority_o,
        input  rl_tid_i, rl_done_i
    );

    modport slave (
        input  rl_insert_o, rl_remove_o, rl_get_o, rl_tid_o, rl_priority_o,
        output rl_tid_i, rl_done_i
    );
endinterface

// File: rtl/task_scheduler.sv
// Turns wake/block requests and timeslice ticks into ready-list commands and
// picks the running task by scanning levels from highest priority down.
module task_scheduler #(
    parameter int NPRI = 5,
    parameter int WDOG = 15
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              tick_i,
    input  logic              wake_i,
    input  logic              block_i,
    input  logic [3:0]        req_tid_i,
    input  logic [2:0]        req_pri_i,
    output logic              req_rdy_o,
    task_scheduler_if.master  rl,
    output logic [4:0]        run_tid_o,
    output logic [2:0]        run_pri_o,
    output logic              run_valid_o,
    output logic              switch_o,
    output logic              err_o,
    output logic [1:0]        dbg_state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [1:0] OP_INS = 2'd0;
    localparam logic [1:0] OP_REM = 2'd1;
    localparam logic [1:0] OP_GET = 2'd2;

    localparam int         WW      = $clog2(WDOG + 1);
    localparam logic [2:0] TOP_PRI = 3'(NPRI - 1);
    localparam logic [4:0] NO_TID  = 5'h1F;

    logic [1:0]    state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [2:0]    sp_q, sp_d;
    logic          tick_pend_q, tick_pend_d;
    logic [3:0]    rl_tid_q, rl_tid_d;
    logic [2:0]    rl_pri_q, rl_pri_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [4:0]    run_tid_q, run_tid_d;
    logic [2:0]    run_pri_q, run_pri_d;
    logic          run_valid_q, run_valid_d;
    logic          switch_q, switch_d;
    logic          err_q, err_d;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sp_d        = sp_q;
        tick_pend_d = tick_pend_q | tick_i;
        rl_tid_d    = rl_tid_q;
        rl_pri_d    = rl_pri_q;
        wdog_d      = wdog_q;
        run_tid_d   = run_tid_q;
        run_pri_d   = run_pri_q;
        run_valid_d = run_valid_q;
        switch_d    = 1'b0;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (block_i) begin
                    op_d     = OP_REM;
                    rl_tid_d = req_tid_i;
                    rl_pri_d = req_pri_i;
                    state_d  = S_CMD;
                    // Blocking the running task forces a fresh pick afterwards.
                    if (run_valid_q && (req_tid_i == run_tid_q[3:0]))
                        tick_pend_d = 1'b1;
                end else if (wake_i) begin
                    op_d     = OP_INS;
                    rl_tid_d = req_tid_i;
                    rl_pri_d = req_pri_i;
                    state_d  = S_CMD;
                end else if (tick_pend_d) begin
                    op_d        = OP_GET;
                    sp_d        = TOP_PRI;
                    rl_tid_d    = req_tid_i;
                    rl_pri_d    = TOP_PRI;
                    tick_pend_d = 1'b0;
                    state_d     = S_CMD;
                end
            end
            S_CMD: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rl.rl_done_i) begin
                    state_d = S_IDLE;
                    if (op_q == OP_GET) begin
                        if (rl.rl_tid_i != NO_TID) begin
                            run_tid_d   = rl.rl_tid_i;
                            run_pri_d   = sp_q;
                            run_valid_d = 1'b1;
                            switch_d    = (rl.rl_tid_i != run_tid_q);
                        end else if (sp_q != 3'd0) begin
                            sp_d     = sp_q - 3'd1;
                            rl_pri_d = sp_q - 3'd1;
                            state_d  = S_CMD;
                        end else begin
                            run_tid_d   = NO_TID;
                            run_valid_d = 1'b0;
                            switch_d    = run_valid_q;
                        end
                    end
                end else if (wdog_q == WW'(WDOG - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            op_q        <= OP_INS;
            sp_q        <= '0;
            tick_pend_q <= 1'b0;
            rl_tid_q    <= '0;
            rl_pri_q    <= '0;
            wdog_q      <= '0;
            run_tid_q   <= NO_TID;
            run_pri_q   <= '0;
            run_valid_q <= 1'b0;
            switch_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sp_q        <= sp_d;
            tick_pend_q <= tick_pend_d;
            rl_tid_q    <= rl_tid_d;
            rl_pri_q    <= rl_pri_d;
            wdog_q      <= wdog_d;
            run_tid_q   <= run_tid_d;
            run_pri_q   <= run_pri_d;
            run_valid_q <= run_valid_d;
            switch_q    <= switch_d;
            err_q       <= err_d;
        end
    end

    // Strobes decode from state so that reset removes them without waiting for a clock.
    assign rl.rl_insert_o   = (state_q == S_CMD) && (op_q == OP_INS);
    assign rl.rl_remove_o   = (state_q == S_CMD) && (op_q == OP_REM);
    assign rl.rl_get_o      = (state_q == S_CMD) && (op_q == OP_GET);
    assign rl.rl_tid_o      = rl_tid_q;
    assign rl.rl_priority_o = rl_pri_q;

    assign req_rdy_o   = (state_q == S_IDLE) && rst_ni;
    assign run_tid_o   = run_tid_q;
    assign run_pri_o   = run_pri_q;
    assign run_valid_o = run_valid_q;
    assign switch_o    = switch_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_task_scheduler.sv
// Directed bench for task_scheduler with a behavioural round-robin ready-list model.
module tb_task_scheduler;

    localparam logic [1:0] OP_INS = 2'd1;
    localparam logic [1:0] OP_REM = 2'd2;
    localparam logic [1:0] OP_GET = 2'd3;

    logic       clk;
    logic       rst_n;
    logic       tick_i, wake_i, block_i;
    logic [3:0] req_tid_i;
    logic [2:0] req_pri_i;
    logic       req_rdy_o;
    logic [4:0] run_tid_o;
    logic [2:0] run_pri_o;
    logic       run_valid_o, switch_o, err_o;
    logic [1:0] dbg_state_o;

    task_scheduler_if rl_if();

    task_scheduler #(.NPRI(5), .WDOG(15)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .tick_i      (tick_i),
        .wake_i      (wake_i),
        .block_i     (block_i),
        .req_tid_i   (req_tid_i),
        .req_pri_i   (req_pri_i),
        .req_rdy_o   (req_rdy_o),
        .rl          (rl_if),
        .run_tid_o   (run_tid_o),
        .run_pri_o   (run_pri_o),
        .run_valid_o (run_valid_o),
        .switch_o    (switch_o),
        .err_o       (err_o),
        .dbg_state_o (dbg_state_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Ready-list model: entries are {pri, tid}; a get rotates the found entry to the tail.
    logic [6:0] list[$];
    logic [8:0] cmd_log[$];
    logic [8:0] exp_q[$];
    logic       never_mode = 1'b0;
    int         hold_cfg   = 0;
    int         hold_left  = 0;
    logic [3:0] lat_tid;
    logic [2:0] lat_pri;
    logic       prev_str;
    int         sw_cnt = 0;

    function automatic int find_pri(input logic [2:0] p);
        for (int i = 0; i < list.size(); i++)
            if (list[i][6:4] == p) return i;
        return -1;
    endfunction

    function automatic int find_ent(input logic [2:0] p, input logic [3:0] t);
        for (int i = 0; i < list.size(); i++)
            if (list[i] == {p, t}) return i;
        return -1;
    endfunction

    function automatic logic [8:0] ent(input logic [1:0] op, input logic [3:0] t, input logic [2:0] p);
        return {op, t, p};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            rl_if.rl_done_i <= 1'b1;
            rl_if.rl_tid_i  <= 5'h1F;
            hold_left       <= 0;
            list.delete();
            cmd_log.delete();
        end else begin
            if (hold_left == 1) rl_if.rl_done_i <= 1'b1;
            if (hold_left != 0) hold_left <= hold_left - 1;
            if (rl_if.rl_insert_o || rl_if.rl_remove_o || rl_if.rl_get_o) begin
                if (!never_mode) chk("strobe_while_busy", 32'(rl_if.rl_done_i), 32'd1);
                lat_tid <= rl_if.rl_tid_o;
                lat_pri <= rl_if.rl_priority_o;
                if (rl_if.rl_insert_o) begin
                    cmd_log.push_back(ent(OP_INS, rl_if.rl_tid_o, rl_if.rl_priority_o));
                    list.push_back({rl_if.rl_priority_o, rl_if.rl_tid_o});
                end else if (rl_if.rl_remove_o) begin
                    cmd_log.push_back(ent(OP_REM, rl_if.rl_tid_o, rl_if.rl_priority_o));
                    if (find_ent(rl_if.rl_priority_o, rl_if.rl_tid_o) >= 0)
                        list.delete(find_ent(rl_if.rl_priority_o, rl_if.rl_tid_o));
                end else begin
                    cmd_log.push_back(ent(OP_GET, 4'd0, rl_if.rl_priority_o));
                    if (find_pri(rl_if.rl_priority_o) >= 0) begin
                        rl_if.rl_tid_i <= {1'b0, list[find_pri(rl_if.rl_priority_o)][3:0]};
                        list.push_back(list[find_pri(rl_if.rl_priority_o)]);
                        list.delete(find_pri(rl_if.rl_priority_o));
                    end else begin
                        rl_if.rl_tid_i <= 5'h1F;
                    end
                end
                if (never_mode) begin
                    rl_if.rl_done_i <= 1'b0;
                    hold_left       <= 0;
                end else if (hold_cfg != 0) begin
                    rl_if.rl_done_i <= 1'b0;
                    hold_left       <= hold_cfg;
                end
            end
        end
    end

    // Strobe shape, operand stability while the model is busy, and switch pulse count
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_str <= 1'b0;
        end else begin
            chk("onehot", 32'($countones({rl_if.rl_insert_o, rl_if.rl_remove_o, rl_if.rl_get_o}) <= 1), 32'd1);
            if (prev_str)
                chk("back2back", 32'({rl_if.rl_insert_o, rl_if.rl_remove_o, rl_if.rl_get_o}), 32'd0);
            prev_str <= rl_if.rl_insert_o | rl_if.rl_remove_o | rl_if.rl_get_o;
            if (hold_left != 0) begin
                chk("hold_tid", 32'(rl_if.rl_tid_o), 32'(lat_tid));
                chk("hold_pri", 32'(rl_if.rl_priority_o), 32'(lat_pri));
            end
            if (switch_o) sw_cnt++;
        end
    end

    // Driver tasks
    task automatic do_req(input logic w, input logic b, input logic t,
                          input logic [3:0] tid, input logic [2:0] pri);
        @(negedge clk);
        wake_i = w; block_i = b; tick_i = t; req_tid_i = tid; req_pri_i = pri;
        @(negedge clk);
        wake_i = 1'b0; block_i = 1'b0; tick_i = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int q = 0;
        int n = 0;
        while (q < 3 && n < 400) begin
            @(negedge clk);
            n++;
            q = req_rdy_o ? q + 1 : 0;
        end
        chk({tag, "_idle"}, 32'(q >= 3), 32'd1);
    endtask

    task automatic wait_get(input string tag);
        int n = 0;
        while (!rl_if.rl_get_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_get_seen"}, 32'(rl_if.rl_get_o), 32'd1);
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, 32'(cmd_log.size()), 32'(exp_q.size()));
        while (exp_q.size() != 0) begin
            logic [8:0] e = exp_q.pop_front();
            logic [8:0] a = 'x;
            if (cmd_log.size() != 0) a = cmd_log.pop_front();
            chk(tag, 32'(a), 32'(e));
        end
        cmd_log.delete();
    endtask

    task automatic check_run(input string tag, input logic [4:0] tid, input logic [2:0] pri,
                             input logic vld, input int sw);
        chk({tag, "_tid"}, 32'(run_tid_o), 32'(tid));
        chk({tag, "_pri"}, 32'(run_pri_o), 32'(pri));
        chk({tag, "_valid"}, 32'(run_valid_o), 32'(vld));
        chk({tag, "_switches"}, 32'(sw_cnt), 32'(sw));
    endtask

    initial begin
        int n;
        rst_n = 1'b0; tick_i = 1'b0; wake_i = 1'b0; block_i = 1'b0;
        req_tid_i = '0; req_pri_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_req_rdy", 32'(req_rdy_o), 32'd1);
        chk("rst_strobes", 32'({rl_if.rl_insert_o, rl_if.rl_remove_o, rl_if.rl_get_o}), 32'd0);
        chk("rst_rl_tid", 32'(rl_if.rl_tid_o), 32'd0);
        chk("rst_rl_pri", 32'(rl_if.rl_priority_o), 32'd0);
        chk("rst_switch", 32'(switch_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        check_run("rst", 5'h1F, 3'd0, 1'b0, 0);

        // Empty ready list: full scan 4..0, nothing to run
        do_req(1'b0, 1'b0, 1'b1, 4'd0, 3'd0);
        wait_quiet("t1");
        for (int p = 4; p >= 0; p--) exp_q.push_back(ent(OP_GET, 4'd0, 3'(p)));
        check_log("t1_log");
        check_run("t1", 5'h1F, 3'd0, 1'b0, 0);

        // Wake tid 3 at pri 2, then tick
        do_req(1'b1, 1'b0, 1'b0, 4'd3, 3'd2);
        wait_quiet("t2a");
        do_req(1'b0, 1'b0, 1'b1, 4'd0, 3'd0);
        wait_quiet("t2b");
        exp_q.push_back(ent(OP_INS, 4'd3, 3'd2));
        exp_q.push_back(ent(OP_GET, 4'd0, 3'd4));
        exp_q.push_back(ent(OP_GET, 4'd0, 3'd3));
        exp_q.push_back(ent(OP_GET, 4'd0, 3'd2));
        check_log("t2_log");
        check_run("t2", 5'd3, 3'd2, 1'b1, 1);

        // Round-robin at pri 4
        do_req(1'b1, 1'b0, 1'b0, 4'd5, 3'd4);
        wait_quiet("t3a");
        do_req(1'b1, 1'b0, 1'b0, 4'd6, 3'd4);
        wait_quiet("t3b");
        do_req(1'b0, 1'b0, 1'b1, 4'd0, 3'd0);
        wait_quiet("t3c");
        check_run("t3_first", 5'd5, 3'd4, 1'b1, 2);
        do_req(1'b0, 1'b0, 1'b1, 4'd0, 3'd0);
        wait_quiet("t3d");
        check_run("t3_second", 5'd6, 3'd4, 1'b1, 3);
        exp_q.push_back(ent(OP_INS, 4'd5, 3'd4));
        exp_q.push_back(ent(OP_INS, 4'd6, 3'd4));
        exp_q.push_back(ent(OP_GET, 4'd0, 3'd4));
        exp_q.push_back(ent(OP_GET, 4'd0, 3'd4));
        check_log("t3_log");

        // Block the running task: remove then automatic rescan
        do_req(1'b0, 1'b1, 1'b0, 4'd6, 3'd4);
        wait_quiet("t4");
        exp_q.push_back(ent(OP_REM, 4'd6, 3'd4));
        exp_q.push_back(ent(OP_GET, 4'd0, 3'd4));
        check_log("t4_log");
        check_run("t4", 5'd5, 3'd4, 1'b1, 4);

        // Wake and tick together with a slow ready list
        hold_cfg = 4;
        do_req(1'b1, 1'b0, 1'b1, 4'd7, 3'd1);
        wait_quiet("t5");
        hold_cfg = 0;
        exp_q.push_back(ent(OP_INS, 4'd7, 3'd1));
        exp_q.push_back(ent(OP_GET, 4'd0, 3'd4));
        check_log("t5_log");
        check_run("t5", 5'd5, 3'd4, 1'b1, 4);

        // Ready list never completes: watchdog error after 15 WAIT cycles
        never_mode = 1'b1;
        do_req(1'b0, 1'b0, 1'b1, 4'd0, 3'd0);
        wait_get("t6");
        n = 0;
        while (!err_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t6_wdog_cycles", 32'(n), 32'd16);
        chk("t6_err", 32'(err_o), 32'd1);
        chk("t6_req_rdy", 32'(req_rdy_o), 32'd1);
        check_run("t6", 5'd5, 3'd4, 1'b1, 4);
        exp_q.push_back(ent(OP_GET, 4'd0, 3'd4));
        check_log("t6_log");

        // Asynchronous reset while waiting
        do_req(1'b0, 1'b0, 1'b1, 4'd0, 3'd0);
        wait_get("t7");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t7_strobes", 32'({rl_if.rl_insert_o, rl_if.rl_remove_o, rl_if.rl_get_o}), 32'd0);
        chk("t7_run_tid", 32'(run_tid_o), 32'h1F);
        chk("t7_run_pri", 32'(run_pri_o), 32'd0);
        chk("t7_run_valid", 32'(run_valid_o), 32'd0);
        chk("t7_err", 32'(err_o), 32'd0);
        chk("t7_switch", 32'(switch_o), 32'd0);
        chk("t7_rl_tid", 32'(rl_if.rl_tid_o), 32'd0);
        chk("t7_rl_pri", 32'(rl_if.rl_priority_o), 32'd0);
        never_mode = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t7_req_rdy", 32'(req_rdy_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule
